xbar_rr_nxm: RTL and testbench

Parametrised N-master x M-slave request/ack crossbar with an independent round-robin arbiter per slave. It generalises the fixed two-master crossbar to any master and slave count. It adds a per-slave ownership lock held until ack, a registered read-data return with an explicit valid strobe, and an idle-timeout pointer reset. It sits between CPU/DMA masters and memory/peripheral slaves on the simple req/ack bus.

---
 rtl/xbar_pkg.sv | 18 +
 rtl/xbar_rr_arb.sv | 93 +++++++++
 rtl/xbar_rr_nxm.sv | 132 +++++++++++++
 tb/tb_xbar_rr_nxm.sv | 477 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xbar_pkg.sv
// Shared types and helpers for the N x M round-robin crossbar.
// Widths are derived per instance from the module parameters via idx_w().
package xbar_pkg;

  localparam logic CMD_RD = 1'b0;
  localparam logic CMD_WR = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } slv_st_e;

  // Index width that stays >= 1 even for a single-entry set.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xbar_rr_arb.sv
// Per-slave round-robin arbiter: IDLE/BUSY ownership FSM,
// rotating pointer and idle-timeout pointer reset.
module xbar_rr_arb
  import xbar_pkg::*;
#(
  parameter int MSTR_NUM = 4,
  parameter int IDL_NUM  = 5,
  parameter int MIW      = idx_w(MSTR_NUM),
  parameter int IDL_W    = $clog2(IDL_NUM + 1)
) (
  input  logic                i_clk,
  input  logic                rst,
  input  logic [MSTR_NUM-1:0] req,
  input  logic                ack,
  output logic                busy,
  output logic [MIW-1:0]      owner,
  output logic                nxt_busy,
  output logic [MIW-1:0]      nxt_owner
);

  slv_st_e          st, st_n;
  logic [MIW-1:0]   own, own_n;
  logic [MIW-1:0]   ptr, ptr_n;
  logic [MIW-1:0]   sel, idx;
  logic [IDL_W-1:0] cnt, cnt_n;
  logic             found;

  // First requester at or after ptr, wrapping.
  always_comb begin
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < MSTR_NUM; i++) begin
      idx = MIW'((int'(ptr) + i) % MSTR_NUM);
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    st_n  = st;
    own_n = own;
    ptr_n = ptr;
    cnt_n = cnt;
    unique case (st)
      IDLE: begin
        if (found) begin
          st_n  = BUSY;
          own_n = sel;
        end
      end
      BUSY: begin
        // Ack or abort both release the slave and rotate.
        if (ack || !req[own]) begin
          st_n  = IDLE;
          ptr_n = (own == MIW'(MSTR_NUM - 1)) ? '0
                                              : own + 1'b1;
        end
      end
      default: st_n = IDLE;
    endcase
    if (st == BUSY || (|req)) begin
      cnt_n = '0;
    end else if (cnt == IDL_W'(IDL_NUM - 1)) begin
      cnt_n = '0;
      ptr_n = '0;
    end else begin
      cnt_n = cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (rst) begin
      st  <= IDLE;
      own <= '0;
      ptr <= '0;
      cnt <= '0;
    end else begin
      st  <= st_n;
      own <= own_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
    end
  end

  assign busy      = (st == BUSY);
  assign owner     = own;
  assign nxt_busy  = (st_n == BUSY);
  assign nxt_owner = own_n;

endmodule

// File: rtl/xbar_rr_nxm.sv
// N-master x M-slave req/ack crossbar, one RR arbiter per slave,
// registered slave-side datapath and registered read-data return.
module xbar_rr_nxm
  import xbar_pkg::*;
#(
  parameter int MSTR_NUM  = 4,
  parameter int SLV_NUM   = 4,
  parameter int DATA_WDTH = 32,
  parameter int ADDR_WDTH = 32,
  parameter int IDL_NUM   = 5
) (
  input  logic                           i_clk,
  input  logic                           rst,
  input  logic [MSTR_NUM-1:0]            i_m_s_req,
  input  logic [MSTR_NUM*ADDR_WDTH-1:0]  i_m_s_addr,
  input  logic [MSTR_NUM-1:0]            i_m_s_cmd,
  input  logic [MSTR_NUM*DATA_WDTH-1:0]  i_m_s_wdata,
  input  logic [SLV_NUM-1:0]             i_s_m_ack,
  input  logic [SLV_NUM*DATA_WDTH-1:0]   i_s_m_rdata,
  output logic [SLV_NUM-1:0]             o_m_s_req,
  output logic [SLV_NUM*ADDR_WDTH-1:0]   o_m_s_addr,
  output logic [SLV_NUM-1:0]             o_m_s_cmd,
  output logic [SLV_NUM*DATA_WDTH-1:0]   o_m_s_wdata,
  output logic [MSTR_NUM-1:0]            o_s_m_ack,
  output logic [MSTR_NUM-1:0]            o_s_m_rvalid,
  output logic [MSTR_NUM*DATA_WDTH-1:0]  o_s_m_rdata,
  output logic [SLV_NUM*$clog2(MSTR_NUM+1)-1:0] o_slv_owner
);

  localparam int SLV_IDX_W  = $clog2(SLV_NUM);
  localparam int MSTR_IDX_W = idx_w(MSTR_NUM);
  localparam int OW         = $clog2(MSTR_NUM + 1);

  logic [ADDR_WDTH-1:0]  m_addr  [MSTR_NUM];
  logic [DATA_WDTH-1:0]  m_wdata [MSTR_NUM];
  logic [SLV_IDX_W-1:0]  m_sel   [MSTR_NUM];
  logic [MSTR_NUM-1:0]   cand    [SLV_NUM];

  logic                  busy     [SLV_NUM];
  logic                  nxt_busy [SLV_NUM];
  logic [MSTR_IDX_W-1:0] own      [SLV_NUM];
  logic [MSTR_IDX_W-1:0] nxt_own  [SLV_NUM];

  logic [ADDR_WDTH-1:0]  s_addr  [SLV_NUM];
  logic                  s_cmd   [SLV_NUM];
  logic [DATA_WDTH-1:0]  s_wdata [SLV_NUM];
  logic [DATA_WDTH-1:0]  rdata_r [MSTR_NUM];

  for (genvar m = 0; m < MSTR_NUM; m++) begin : g_mst
    assign m_addr[m]  = i_m_s_addr[m*ADDR_WDTH +: ADDR_WDTH];
    assign m_wdata[m] = i_m_s_wdata[m*DATA_WDTH +: DATA_WDTH];
    assign m_sel[m]   = m_addr[m][ADDR_WDTH-1 -: SLV_IDX_W];
    assign o_s_m_rdata[m*DATA_WDTH +: DATA_WDTH] = rdata_r[m];
  end

  always_comb begin
    for (int s = 0; s < SLV_NUM; s++) begin
      cand[s] = '0;
      for (int m = 0; m < MSTR_NUM; m++) begin
        cand[s][m] = i_m_s_req[m]
                   && (m_sel[m] == SLV_IDX_W'(s));
      end
    end
  end

  for (genvar s = 0; s < SLV_NUM; s++) begin : g_slv
    xbar_rr_arb #(
      .MSTR_NUM (MSTR_NUM),
      .IDL_NUM  (IDL_NUM)
    ) u_arb (
      .i_clk     (i_clk),
      .rst       (rst),
      .req       (cand[s]),
      .ack       (i_s_m_ack[s]),
      .busy      (busy[s]),
      .owner     (own[s]),
      .nxt_busy  (nxt_busy[s]),
      .nxt_owner (nxt_own[s])
    );

    // Slave-side bundle follows the owner while held, zero otherwise.
    always_ff @(posedge i_clk) begin
      if (rst) begin
        s_addr[s]  <= '0;
        s_cmd[s]   <= CMD_RD;
        s_wdata[s] <= '0;
      end else if (nxt_busy[s]) begin
        s_addr[s]  <= m_addr[nxt_own[s]];
        s_cmd[s]   <= i_m_s_cmd[nxt_own[s]];
        s_wdata[s] <= m_wdata[nxt_own[s]];
      end else begin
        s_addr[s]  <= '0;
        s_cmd[s]   <= CMD_RD;
        s_wdata[s] <= '0;
      end
    end

    assign o_m_s_req[s] = busy[s];
    assign o_m_s_cmd[s] = s_cmd[s];
    assign o_m_s_addr[s*ADDR_WDTH +: ADDR_WDTH]  = s_addr[s];
    assign o_m_s_wdata[s*DATA_WDTH +: DATA_WDTH] = s_wdata[s];
    assign o_slv_owner[s*OW +: OW] =
      busy[s] ? OW'(own[s]) + OW'(1) : '0;
  end

  always_comb begin
    o_s_m_ack = '0;
    for (int s = 0; s < SLV_NUM; s++) begin
      if (busy[s] && i_s_m_ack[s]) begin
        o_s_m_ack[own[s]] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (rst) begin
      o_s_m_rvalid <= '0;
      for (int m = 0; m < MSTR_NUM; m++) begin
        rdata_r[m] <= '0;
      end
    end else begin
      o_s_m_rvalid <= '0;
      for (int s = 0; s < SLV_NUM; s++) begin
        if (busy[s] && i_s_m_ack[s] && s_cmd[s] == CMD_RD) begin
          o_s_m_rvalid[own[s]] <= 1'b1;
          rdata_r[own[s]] <= i_s_m_rdata[s*DATA_WDTH +: DATA_WDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_xbar_rr_nxm.sv
// Directed self-checking bench for xbar_rr_nxm (4 masters x 4 slaves).
module tb_xbar_rr_nxm;

  localparam int MN = 4;
  localparam int SN = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int OW = 3;

  logic i_clk = 1'b0;
  logic rst   = 1'b1;

  logic [MN-1:0] m_req = '0;
  logic [MN-1:0] m_cmd = '0;
  logic [AW-1:0] m_addr [MN];
  logic [DW-1:0] m_wd   [MN];
  logic [SN-1:0] s_ack = '0;
  logic [DW-1:0] s_rd   [SN];

  logic [MN*AW-1:0] pk_addr;
  logic [MN*DW-1:0] pk_wd;
  logic [SN*DW-1:0] pk_rd;

  logic [SN-1:0]    o_m_s_req;
  logic [SN*AW-1:0] o_m_s_addr;
  logic [SN-1:0]    o_m_s_cmd;
  logic [SN*DW-1:0] o_m_s_wdata;
  logic [MN-1:0]    o_s_m_ack;
  logic [MN-1:0]    o_s_m_rvalid;
  logic [MN*DW-1:0] o_s_m_rdata;
  logic [SN*OW-1:0] o_slv_owner;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 i_clk = ~i_clk;

  always_comb begin
    for (int i = 0; i < MN; i++) begin
      pk_addr[i*AW +: AW] = m_addr[i];
      pk_wd[i*DW +: DW]   = m_wd[i];
    end
    for (int i = 0; i < SN; i++) begin
      pk_rd[i*DW +: DW] = s_rd[i];
    end
  end

  xbar_rr_nxm #(
    .MSTR_NUM  (MN),
    .SLV_NUM   (SN),
    .DATA_WDTH (DW),
    .ADDR_WDTH (AW),
    .IDL_NUM   (5)
  ) dut (
    .i_clk        (i_clk),
    .rst          (rst),
    .i_m_s_req    (m_req),
    .i_m_s_addr   (pk_addr),
    .i_m_s_cmd    (m_cmd),
    .i_m_s_wdata  (pk_wd),
    .i_s_m_ack    (s_ack),
    .i_s_m_rdata  (pk_rd),
    .o_m_s_req    (o_m_s_req),
    .o_m_s_addr   (o_m_s_addr),
    .o_m_s_cmd    (o_m_s_cmd),
    .o_m_s_wdata  (o_m_s_wdata),
    .o_s_m_ack    (o_s_m_ack),
    .o_s_m_rvalid (o_s_m_rvalid),
    .o_s_m_rdata  (o_s_m_rdata),
    .o_slv_owner  (o_slv_owner)
  );

  function automatic logic [AW-1:0] saddr(input int s);
    return o_m_s_addr[s*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] swd(input int s);
    return o_m_s_wdata[s*DW +: DW];
  endfunction

  function automatic logic [OW-1:0] sown(input int s);
    return o_slv_owner[s*OW +: OW];
  endfunction

  function automatic logic [DW-1:0] mrd(input int m);
    return o_s_m_rdata[m*DW +: DW];
  endfunction

  task automatic cyc;
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cyc();
    cyc();
    n_chk++;
    if (o_m_s_req !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_req got=%b exp=0000", o_m_s_req);
    end
    n_chk++;
    if (o_slv_owner !== '0) begin
      n_fail++;
      $display("FAIL rst_owner got=%h exp=0", o_slv_owner);
    end
    n_chk++;
    if (o_s_m_rvalid !== 4'b0000 || o_s_m_rdata !== '0) begin
      n_fail++;
      $display("FAIL rst_rd got=%b/%h exp=0/0",
               o_s_m_rvalid, o_s_m_rdata);
    end
    n_chk++;
    if (o_m_s_addr !== '0 || o_m_s_wdata !== '0) begin
      n_fail++;
      $display("FAIL rst_dp got=%h/%h exp=0/0",
               o_m_s_addr, o_m_s_wdata);
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_single_read;
    m_req[0]  = 1'b1;
    m_addr[0] = 32'h4000_0010;
    m_cmd[0]  = 1'b0;
    #1;
    n_chk++;
    if (o_m_s_req !== 4'b0000) begin
      n_fail++;
      $display("FAIL rd_latency got=%b exp=0000", o_m_s_req);
    end
    cyc();
    n_chk++;
    if (o_m_s_req !== 4'b0010 || sown(1) !== 3'd1) begin
      n_fail++;
      $display("FAIL rd_grant got=%b/%0d exp=0010/1",
               o_m_s_req, sown(1));
    end
    n_chk++;
    if (saddr(1) !== 32'h4000_0010 || o_m_s_cmd[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_addr got=%h/%b exp=40000010/0",
               saddr(1), o_m_s_cmd[1]);
    end
    repeat (3) cyc();
    n_chk++;
    if (o_s_m_ack !== 4'b0000 || o_m_s_req !== 4'b0010) begin
      n_fail++;
      $display("FAIL rd_wait got=%b/%b exp=0000/0010",
               o_s_m_ack, o_m_s_req);
    end
    s_ack[1] = 1'b1;
    s_rd[1]  = 32'hA5A5_0001;
    #1;
    n_chk++;
    if (o_s_m_ack !== 4'b0001 || o_s_m_rvalid !== 4'b0000) begin
      n_fail++;
      $display("FAIL rd_ack got=%b/%b exp=0001/0000",
               o_s_m_ack, o_s_m_rvalid);
    end
    cyc();
    s_ack    = '0;
    m_req[0] = 1'b0;
    #1;
    n_chk++;
    if (o_s_m_rvalid !== 4'b0001 || mrd(0) !== 32'hA5A5_0001) begin
      n_fail++;
      $display("FAIL rd_data got=%b/%h exp=0001/a5a50001",
               o_s_m_rvalid, mrd(0));
    end
    n_chk++;
    if (o_m_s_req !== 4'b0000 || o_s_m_ack !== 4'b0000) begin
      n_fail++;
      $display("FAIL rd_release got=%b/%b exp=0000/0000",
               o_m_s_req, o_s_m_ack);
    end
    cyc();
    n_chk++;
    if (o_s_m_rvalid !== 4'b0000 || mrd(0) !== 32'hA5A5_0001) begin
      n_fail++;
      $display("FAIL rd_strobe got=%b/%h exp=0000/a5a50001",
               o_s_m_rvalid, mrd(0));
    end
  endtask

  task automatic test_rr_fairness;
    int ord [6] = '{0, 1, 2, 3, 0, 1};
    for (int m = 0; m < MN; m++) begin
      m_req[m]  = 1'b1;
      m_addr[m] = 32'h8000_0000 | (m * 16);
      m_cmd[m]  = 1'b1;
      m_wd[m]   = 32'hD000_0000 + m;
    end
    for (int k = 0; k < 6; k++) begin
      cyc();
      n_chk++;
      if (sown(2) !== OW'(ord[k] + 1)
          || swd(2) !== 32'hD000_0000 + ord[k]
          || o_m_s_cmd[2] !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_grant%0d got=%0d/%h exp=%0d/%h",
                 k, sown(2), swd(2), ord[k] + 1,
                 32'hD000_0000 + ord[k]);
      end
      s_ack[2] = 1'b1;
      #1;
      n_chk++;
      if (o_s_m_ack !== (4'b0001 << ord[k])) begin
        n_fail++;
        $display("FAIL rr_ack%0d got=%b exp=%b",
                 k, o_s_m_ack, 4'b0001 << ord[k]);
      end
      cyc();
      s_ack[2] = 1'b0;
      n_chk++;
      if (o_m_s_req[2] !== 1'b0 || o_s_m_rvalid !== 4'b0000) begin
        n_fail++;
        $display("FAIL rr_idle%0d got=%b/%b exp=0/0000",
                 k, o_m_s_req[2], o_s_m_rvalid);
      end
    end
    m_req = '0;
    m_cmd = '0;
  endtask

  task automatic test_parallel;
    m_req[0]  = 1'b1;
    m_addr[0] = 32'h0000_0100;
    m_req[1]  = 1'b1;
    m_addr[1] = 32'hC000_0200;
    cyc();
    n_chk++;
    if (o_m_s_req !== 4'b1001 || sown(0) !== 3'd1
        || sown(3) !== 3'd2) begin
      n_fail++;
      $display("FAIL par_grant got=%b/%0d/%0d exp=1001/1/2",
               o_m_s_req, sown(0), sown(3));
    end
    s_ack[3] = 1'b1;
    s_rd[3]  = 32'h3333_3333;
    s_rd[0]  = 32'h0BAD_0BAD;
    #1;
    n_chk++;
    if (o_s_m_ack !== 4'b0010) begin
      n_fail++;
      $display("FAIL par_ack3 got=%b exp=0010", o_s_m_ack);
    end
    cyc();
    s_ack[3] = 1'b0;
    m_req[1] = 1'b0;
    n_chk++;
    if (o_s_m_rvalid !== 4'b0010 || mrd(1) !== 32'h3333_3333
        || mrd(0) !== 32'hA5A5_0001) begin
      n_fail++;
      $display("FAIL par_rd3 got=%b/%h/%h exp=0010/33333333/a5a50001",
               o_s_m_rvalid, mrd(1), mrd(0));
    end
    n_chk++;
    if (o_m_s_req !== 4'b0001) begin
      n_fail++;
      $display("FAIL par_req got=%b exp=0001", o_m_s_req);
    end
    s_ack[0] = 1'b1;
    s_rd[0]  = 32'h0000_0C0C;
    #1;
    n_chk++;
    if (o_s_m_ack !== 4'b0001) begin
      n_fail++;
      $display("FAIL par_ack0 got=%b exp=0001", o_s_m_ack);
    end
    cyc();
    s_ack    = '0;
    m_req[0] = 1'b0;
    n_chk++;
    if (o_s_m_rvalid !== 4'b0001 || mrd(0) !== 32'h0000_0C0C
        || mrd(1) !== 32'h3333_3333) begin
      n_fail++;
      $display("FAIL par_rd0 got=%b/%h/%h exp=0001/00000c0c/33333333",
               o_s_m_rvalid, mrd(0), mrd(1));
    end
  endtask

  task automatic idle_case(input int n, input int exp_m);
    m_req[2]  = 1'b1;
    m_addr[2] = 32'h0000_0004;
    m_cmd[2]  = 1'b1;
    m_wd[2]   = 32'h2222_0000 + n;
    cyc();
    n_chk++;
    if (sown(0) !== 3'd3) begin
      n_fail++;
      $display("FAIL idle%0d_m2 got=%0d exp=3", n, sown(0));
    end
    s_ack[0] = 1'b1;
    cyc();
    s_ack[0] = 1'b0;
    m_req[2] = 1'b0;
    repeat (n - 1) cyc();
    cyc();
    m_req[1]  = 1'b1;
    m_addr[1] = 32'h0000_0008;
    m_cmd[1]  = 1'b1;
    m_req[3]  = 1'b1;
    m_addr[3] = 32'h0000_000C;
    m_cmd[3]  = 1'b1;
    cyc();
    n_chk++;
    if (sown(0) !== OW'(exp_m + 1)) begin
      n_fail++;
      $display("FAIL idle%0d_win got=%0d exp=%0d",
               n, sown(0), exp_m + 1);
    end
    s_ack[0] = 1'b1;
    cyc();
    s_ack = '0;
    m_req = '0;
    m_cmd = '0;
  endtask

  task automatic test_idle_timeout;
    idle_case(4, 3);
    idle_case(5, 1);
  endtask

  task automatic test_abort;
    m_req[1]  = 1'b1;
    m_addr[1] = 32'h4000_0020;
    m_cmd[1]  = 1'b0;
    cyc();
    n_chk++;
    if (sown(1) !== 3'd2) begin
      n_fail++;
      $display("FAIL ab_grant got=%0d exp=2", sown(1));
    end
    cyc();
    m_req[1] = 1'b0;
    #1;
    n_chk++;
    if (o_s_m_ack !== 4'b0000 || o_m_s_req[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL ab_noack got=%b/%b exp=0000/1",
               o_s_m_ack, o_m_s_req[1]);
    end
    cyc();
    n_chk++;
    if (o_m_s_req[1] !== 1'b0 || sown(1) !== 3'd0
        || saddr(1) !== '0 || o_s_m_rvalid !== 4'b0000) begin
      n_fail++;
      $display("FAIL ab_idle got=%b/%0d/%h/%b exp=0/0/0/0000",
               o_m_s_req[1], sown(1), saddr(1), o_s_m_rvalid);
    end
    s_ack[1] = 1'b1;
    s_rd[1]  = 32'hFFFF_FFFF;
    #1;
    n_chk++;
    if (o_s_m_ack !== 4'b0000) begin
      n_fail++;
      $display("FAIL ab_stray_ack got=%b exp=0000", o_s_m_ack);
    end
    cyc();
    s_ack = '0;
    n_chk++;
    if (o_s_m_rvalid !== 4'b0000 || mrd(1) !== 32'h3333_3333) begin
      n_fail++;
      $display("FAIL ab_stray_rd got=%b/%h exp=0000/33333333",
               o_s_m_rvalid, mrd(1));
    end
    m_req[1] = 1'b1;
    cyc();
    m_req[1] = 1'b0;
    s_ack[1] = 1'b1;
    s_rd[1]  = 32'h1234_5678;
    #1;
    n_chk++;
    if (o_s_m_ack !== 4'b0010) begin
      n_fail++;
      $display("FAIL ab_drop_ack got=%b exp=0010", o_s_m_ack);
    end
    cyc();
    s_ack = '0;
    n_chk++;
    if (o_s_m_rvalid !== 4'b0010 || mrd(1) !== 32'h1234_5678
        || o_m_s_req[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL ab_drop_rd got=%b/%h/%b exp=0010/12345678/0",
               o_s_m_rvalid, mrd(1), o_m_s_req[1]);
    end
  endtask

  task automatic test_reset_mid;
    m_req[1]  = 1'b1;
    m_addr[1] = 32'h0000_0010;
    m_cmd[1]  = 1'b1;
    cyc();
    s_ack[0] = 1'b1;
    cyc();
    s_ack     = '0;
    m_req[1]  = 1'b0;
    m_req[0]  = 1'b1;
    m_addr[0] = 32'h0000_0040;
    m_cmd[0]  = 1'b0;
    cyc();
    n_chk++;
    if (sown(0) !== 3'd1) begin
      n_fail++;
      $display("FAIL rm_busy got=%0d exp=1", sown(0));
    end
    rst = 1'b1;
    cyc();
    rst      = 1'b0;
    m_req[0] = 1'b0;
    n_chk++;
    if (o_m_s_req !== 4'b0000 || o_slv_owner !== '0
        || saddr(0) !== '0 || o_s_m_rvalid !== 4'b0000) begin
      n_fail++;
      $display("FAIL rm_clear got=%b/%h/%h/%b exp=0000/0/0/0000",
               o_m_s_req, o_slv_owner, saddr(0), o_s_m_rvalid);
    end
    s_ack[0] = 1'b1;
    s_rd[0]  = 32'hDEAD_BEEF;
    #1;
    n_chk++;
    if (o_s_m_ack !== 4'b0000) begin
      n_fail++;
      $display("FAIL rm_late_ack got=%b exp=0000", o_s_m_ack);
    end
    cyc();
    s_ack = '0;
    n_chk++;
    if (o_s_m_rvalid !== 4'b0000 || mrd(0) !== '0
        || mrd(1) !== '0) begin
      n_fail++;
      $display("FAIL rm_rdata got=%b/%h/%h exp=0000/0/0",
               o_s_m_rvalid, mrd(0), mrd(1));
    end
    m_req[1]  = 1'b1;
    m_addr[1] = 32'h0000_0010;
    m_cmd[1]  = 1'b1;
    m_req[2]  = 1'b1;
    m_addr[2] = 32'h0000_0020;
    m_cmd[2]  = 1'b1;
    cyc();
    n_chk++;
    if (sown(0) !== 3'd2) begin
      n_fail++;
      $display("FAIL rm_ptr got=%0d exp=2", sown(0));
    end
    s_ack[0] = 1'b1;
    cyc();
    s_ack = '0;
    m_req = '0;
    cyc();
  endtask

  initial begin
    for (int i = 0; i < MN; i++) begin
      m_addr[i] = '0;
      m_wd[i]   = '0;
    end
    for (int i = 0; i < SN; i++) begin
      s_rd[i] = '0;
    end
    test_reset();
    test_single_read();
    test_rr_fairness();
    test_parallel();
    test_idle_timeout();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
